// File: rtl/fe_sched.sv
// Round-robin scheduler sharing one fe/ack/senack four-phase handshake among NREQ requesters.
// Optional watchdog abort enabled by defining FE_SCHED_TIMEOUT_EN.
module fe_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            fe,
  input  logic            ack,
  input  logic            senack,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1 || TIMEOUT > 65535 ||
      IDW != $clog2(NREQ)) begin : g_bad_param
  end

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d, ptr_q, ptr_d, win, ptr_nxt;
  logic            fe_q, fe_d, busy_q, busy_d, done_q, done_d;
  logic            found;
`ifdef FE_SCHED_TIMEOUT_EN
  logic [15:0]     wdog_q, wdog_d;
  logic            err_q, err_d;
`endif

  // Rotating priority scan starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int s;
      s = int'(ptr_q) + i;
      if (s >= NREQ) s = s - NREQ;
      if (!found && req[s]) begin
        found = 1'b1;
        win   = s[IDW-1:0];
      end
    end
  end

  assign ptr_nxt = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    fe_d    = fe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
        id_d    = win;
        fe_d    = 1'b1;
        busy_d  = 1'b1;
        state_d = REQ;
      end
      REQ: if (ack) begin
        fe_d    = 1'b0;
        state_d = XFER;
      end
      XFER: if (senack) state_d = REL;
      REL: if (!ack && !senack) begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ptr_d   = ptr_nxt;
      end
      default: state_d = IDLE;
    endcase
`ifdef FE_SCHED_TIMEOUT_EN
    err_d  = 1'b0;
    wdog_d = '0;
    if (state_q != IDLE && state_d == state_q) begin
      if (wdog_q == 16'(TIMEOUT-1)) begin
        // Stalled phase: drop the channel and move priority past the winner.
        state_d = IDLE;
        gnt_d   = '0;
        fe_d    = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b1;
        ptr_d   = ptr_nxt;
      end else begin
        wdog_d  = wdog_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FE_SCHED_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FE_SCHED_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign id   = id_q;
  assign fe   = fe_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef FE_SCHED_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_fe_sched.sv
// Directed bench for fe_sched: arbitration order, handshake walk, reset and watchdog behaviour.
module tb_fe_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            ack = 1'b0, senack = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  id;
  logic            fe, busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  fe_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .id(id), .fe(fe),
    .ack(ack), .senack(senack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input int exp_id);
    chk({tag, " gnt"}, 32'(gnt), 32'(1) << exp_id);
    chk({tag, " id"}, 32'(id), 32'(exp_id));
    chk({tag, " fe"}, 32'(fe), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
  endtask

  // Walks ack, senack, release from REQ; leaves bench one edge after done.
  task automatic handshake(input string tag, input int exp_id);
    ack = 1'b1; step();
    chk({tag, " fe low in XFER"}, 32'(fe), 32'd0);
    ack = 1'b0; senack = 1'b1; step();
    chk({tag, " no early done"}, 32'(done), 32'd0);
    chk({tag, " id held"}, 32'(id), 32'(exp_id));
    senack = 1'b0; step();
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " gnt cleared"}, 32'(gnt), 32'd0);
    chk({tag, " busy cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset id", 32'(id), 32'd0);
    chk("reset fe", 32'(fe), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("idle no req", 32'(busy), 32'd0);

    // Fairness from ptr=0: ids 0,1,2,3,0,1,2,3.
    req = 4'b1111;
    step();
    for (int t = 0; t < 8; t++) begin
      chk_grant($sformatf("fair%0d", t), t % 4);
      handshake($sformatf("fair%0d", t), t % 4);
      if (t != 7) step();
    end
    req = '0;
    step();
    chk("fair done one-shot", 32'(done), 32'd0);

    // Single request for requester 2, ptr=0 before.
    req = 4'b0100;
    step();
    chk_grant("single", 2);
    req = '0;
    handshake("single", 2);
    step();
    chk("single done one-shot", 32'(done), 32'd0);
    // ptr now 3: requesters 0 and 3 pending -> 3 wins.
    req = 4'b1001;
    step();
    chk_grant("ptr3", 3);
    req = '0;
    handshake("ptr3", 3);
    step();

    // Drop request mid-transfer.
    req = 4'b0010;
    step();
    chk_grant("drop", 1);
    ack = 1'b1; step();
    ack = 1'b0; req = '0; step();
    chk("drop busy in XFER", 32'(busy), 32'd1);
    senack = 1'b1; step();
    chk("drop id in REL", 32'(id), 32'd1);
    senack = 1'b0; step();
    chk("drop done", 32'(done), 32'd1);
    chk("drop id", 32'(id), 32'd1);
    step();

    // Simultaneous ack and senack.
    req = 4'b0001;
    step();
    chk_grant("simul", 0);
    req = '0;
    ack = 1'b1; senack = 1'b1; step();
    chk("simul fe in XFER", 32'(fe), 32'd0);
    chk("simul busy XFER", 32'(busy), 32'd1);
    step();
    chk("simul held REL", 32'(done), 32'd0);
    step();
    chk("simul stay REL", 32'(done), 32'd0);
    chk("simul stay busy", 32'(busy), 32'd1);
    ack = 1'b0; senack = 1'b0; step();
    chk("simul done", 32'(done), 32'd1);
    step();

    // Async reset in XFER between edges.
    req = 4'b0100;
    step();
    chk_grant("areset pre", 2);
    req = '0;
    ack = 1'b1; step();
    ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("areset gnt", 32'(gnt), 32'd0);
    chk("areset fe", 32'(fe), 32'd0);
    chk("areset busy", 32'(busy), 32'd0);
    chk("areset done", 32'(done), 32'd0);
    req = 4'b0001;
    reset = 1'b1;
    step();
    chk_grant("areset regrant", 0);
    req = '0;
    handshake("areset regrant", 0);
    step();

    // Stalled handshake: ack held low.
    req = 4'b0010;
    step();
    chk_grant("wdog", 1);
    req = '0;
`ifdef FE_SCHED_TIMEOUT_EN
    for (int c = 0; c < 9; c++) begin
      step();
      chk($sformatf("wdog wait%0d fe", c), 32'(fe), 32'd1);
      chk($sformatf("wdog wait%0d err", c), 32'(err), 32'd0);
    end
    step();
    chk("wdog err", 32'(err), 32'd1);
    chk("wdog fe", 32'(fe), 32'd0);
    chk("wdog busy", 32'(busy), 32'd0);
    chk("wdog gnt", 32'(gnt), 32'd0);
    chk("wdog done", 32'(done), 32'd0);
    req = 4'b0011;
    step();
    chk("wdog err one-shot", 32'(err), 32'd0);
    chk("wdog ptr advanced", 32'(id), 32'd0);
    req = '0;
    handshake("wdog after", 0);
`else
    begin
      int bad_fe, bad_err;
      bad_fe = 0; bad_err = 0;
      for (int c = 0; c < 1000; c++) begin
        step();
        if (fe !== 1'b1) bad_fe++;
        if (err !== 1'b0) bad_err++;
      end
      chk("stall fe cycles lost", 32'(bad_fe), 32'd0);
      chk("stall err cycles", 32'(bad_err), 32'd0);
      chk("stall busy", 32'(busy), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
